// File: rtl/cv32e40p_retire_trace_buffer_if.sv
// Retirement-stream input and trace-sink output bundle for the retire trace buffer.
// The buffer uses the slave view; the environment (core side plus sink) uses master.
interface cv32e40p_retire_trace_buffer_if #(
   parameter int ORDER_W = 32
);
   logic               ret_valid_i;
   logic [31:0]        ret_pc_i;
   logic [31:0]        ret_insn_i;
   logic               ret_rd_we_i;
   logic [4:0]         ret_rd_addr_i;
   logic [31:0]        ret_rd_wdata_i;
   logic               ret_trap_i;

   logic               trace_valid_o;
   logic               trace_ready_i;
   logic [31:0]        trace_pc_o;
   logic [31:0]        trace_insn_o;
   logic               trace_rd_we_o;
   logic [4:0]         trace_rd_addr_o;
   logic [31:0]        trace_rd_wdata_o;
   logic               trace_trap_o;
   logic [ORDER_W-1:0] trace_order_o;
   logic               trace_gap_o;

   modport master (
      output ret_valid_i, ret_pc_i, ret_insn_i, ret_rd_we_i, ret_rd_addr_i,
             ret_rd_wdata_i, ret_trap_i, trace_ready_i,
      input  trace_valid_o, trace_pc_o, trace_insn_o, trace_rd_we_o, trace_rd_addr_o,
             trace_rd_wdata_o, trace_trap_o, trace_order_o, trace_gap_o
   );

   modport slave (
      input  ret_valid_i, ret_pc_i, ret_insn_i, ret_rd_we_i, ret_rd_addr_i,
             ret_rd_wdata_i, ret_trap_i, trace_ready_i,
      output trace_valid_o, trace_pc_o, trace_insn_o, trace_rd_we_o, trace_rd_addr_o,
             trace_rd_wdata_o, trace_trap_o, trace_order_o, trace_gap_o
   );
endinterface

// File: rtl/cv32e40p_retire_trace_buffer.sv
// Retirement trace buffer: tags each captured retirement with an order number, queues it
// in a small FIFO for a valid/ready sink, and counts/flags records lost to overflow.
module cv32e40p_retire_trace_buffer #(
   parameter int DEPTH   = 4,
   parameter int ORDER_W = 32,
   parameter int DROP_W  = 16
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        en_i,
   input  logic                        flush_i,
   cv32e40p_retire_trace_buffer_if.slave trc,
   output logic [$clog2(DEPTH):0]      level_o,
   output logic [DROP_W-1:0]           drop_cnt_o,
   output logic                        overflow_o
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   typedef struct packed {
      logic [31:0]        pc;
      logic [31:0]        insn;
      logic               rd_we;
      logic [4:0]         rd_addr;
      logic [31:0]        rd_wdata;
      logic               trap;
      logic [ORDER_W-1:0] order;
      logic               gap;
   } rec_t;

   rec_t               mem_q [DEPTH];
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [LVL_W-1:0]   level_q, level_d;
   logic [ORDER_W-1:0] order_q, order_d;
   logic [DROP_W-1:0]  drop_cnt_q, drop_cnt_d;
   logic               overflow_q, overflow_d;
   logic               gap_pending_q, gap_pending_d;

   logic cap, pop, full, push, drop, valid;
   rec_t wr_rec, head;

   assign cap   = trc.ret_valid_i & en_i;
   assign valid = (level_q != '0);
   assign pop   = valid & trc.trace_ready_i;
   assign full  = (level_q == LVL_W'(DEPTH));
   assign push  = cap & (~full | pop);
   assign drop  = cap & full & ~pop;

   assign wr_rec = '{pc:       trc.ret_pc_i,
                     insn:     trc.ret_insn_i,
                     rd_we:    trc.ret_rd_we_i,
                     rd_addr:  trc.ret_rd_addr_i,
                     rd_wdata: trc.ret_rd_wdata_i,
                     trap:     trc.ret_trap_i,
                     order:    order_q,
                     gap:      gap_pending_q};

   always_comb begin
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      level_d       = level_q;
      order_d       = order_q;
      drop_cnt_d    = drop_cnt_q;
      overflow_d    = overflow_q;
      gap_pending_d = gap_pending_q;
      // An order number is burned on every capture, even if the record never gets stored.
      if (cap) order_d = order_q + ORDER_W'(1);
      if (flush_i) begin
         rd_ptr_d      = '0;
         wr_ptr_d      = '0;
         level_d       = '0;
         gap_pending_d = gap_pending_q | cap;
      end else begin
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (push) begin
            wr_ptr_d      = wr_ptr_q + PTR_W'(1);
            gap_pending_d = 1'b0;
         end
         if (drop) begin
            if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_W'(1);
            overflow_d    = 1'b1;
            gap_pending_d = 1'b1;
         end
         level_d = level_q + LVL_W'(push) - LVL_W'(pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         level_q       <= '0;
         order_q       <= '0;
         drop_cnt_q    <= '0;
         overflow_q    <= 1'b0;
         gap_pending_q <= 1'b0;
      end else begin
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         level_q       <= level_d;
         order_q       <= order_d;
         drop_cnt_q    <= drop_cnt_d;
         overflow_q    <= overflow_d;
         gap_pending_q <= gap_pending_d;
      end
   end

   // Storage needs no reset: level_q gates every read of it.
   always_ff @(posedge clk_i) begin
      if (!rst_i && !flush_i && push) mem_q[wr_ptr_q] <= wr_rec;
   end

   assign head = valid ? mem_q[rd_ptr_q] : '0;

   assign trc.trace_valid_o    = valid;
   assign trc.trace_pc_o       = head.pc;
   assign trc.trace_insn_o     = head.insn;
   assign trc.trace_rd_we_o    = head.rd_we;
   assign trc.trace_rd_addr_o  = head.rd_addr;
   assign trc.trace_rd_wdata_o = head.rd_wdata;
   assign trc.trace_trap_o     = head.trap;
   assign trc.trace_order_o    = head.order;
   assign trc.trace_gap_o      = head.gap;

   assign level_o    = level_q;
   assign drop_cnt_o = drop_cnt_q;
   assign overflow_o = overflow_q;
endmodule

// File: tb/tb_cv32e40p_retire_trace_buffer.sv
// Randomized and directed bench for the retire trace buffer against a queue-based model.
module tb_cv32e40p_retire_trace_buffer;
   localparam int DEPTH   = 4;
   localparam int ORDER_W = 4;
   localparam int DROP_W  = 2;
   localparam int DROP_MAX = (1 << DROP_W) - 1;

   logic clk_i = 1'b0;
   logic rst_i, en_i, flush_i;
   logic [$clog2(DEPTH):0] level_o;
   logic [DROP_W-1:0]      drop_cnt_o;
   logic                   overflow_o;

   cv32e40p_retire_trace_buffer_if #(.ORDER_W(ORDER_W)) trc ();

   cv32e40p_retire_trace_buffer #(.DEPTH(DEPTH), .ORDER_W(ORDER_W), .DROP_W(DROP_W)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .en_i       (en_i),
      .flush_i    (flush_i),
      .trc        (trc),
      .level_o    (level_o),
      .drop_cnt_o (drop_cnt_o),
      .overflow_o (overflow_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] insn;
      logic        rd_we;
      logic [4:0]  rd_addr;
      logic [31:0] rd_wdata;
      logic        trap;
      int          order;
      logic        gap;
   } m_rec_t;

   m_rec_t m_q[$];
   int     m_order, m_drops;
   bit     m_ovf, m_gap_pend;
   int     checks_cnt = 0;
   int     errors_cnt = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks_cnt++;
      if (got !== exp) begin
         errors_cnt++;
         $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic compare_model();
      check_eq("valid", 64'(trc.trace_valid_o), 64'(m_q.size() != 0));
      check_eq("level", 64'(level_o), 64'(m_q.size()));
      check_eq("drop_cnt", 64'(drop_cnt_o), 64'(m_drops));
      check_eq("overflow", 64'(overflow_o), 64'(m_ovf));
      if (m_q.size() != 0) begin
         check_eq("pc", 64'(trc.trace_pc_o), 64'(m_q[0].pc));
         check_eq("insn", 64'(trc.trace_insn_o), 64'(m_q[0].insn));
         check_eq("rd_we", 64'(trc.trace_rd_we_o), 64'(m_q[0].rd_we));
         check_eq("rd_addr", 64'(trc.trace_rd_addr_o), 64'(m_q[0].rd_addr));
         check_eq("rd_wdata", 64'(trc.trace_rd_wdata_o), 64'(m_q[0].rd_wdata));
         check_eq("trap", 64'(trc.trace_trap_o), 64'(m_q[0].trap));
         check_eq("order", 64'(trc.trace_order_o), 64'(m_q[0].order));
         check_eq("gap", 64'(trc.trace_gap_o), 64'(m_q[0].gap));
      end
   endtask

   // One clock: drive inputs, advance the model on the same inputs, then compare after the edge.
   task automatic step(input bit rst, input bit v, input bit en, input bit fl, input bit rdy,
                       input logic [31:0] pc);
      m_rec_t r;
      bit cap;
      rst_i               = rst;
      en_i                = en;
      flush_i             = fl;
      trc.trace_ready_i   = rdy;
      trc.ret_valid_i     = v;
      trc.ret_pc_i        = pc;
      trc.ret_insn_i      = $urandom;
      trc.ret_rd_we_i     = 1'($urandom);
      trc.ret_rd_addr_i   = 5'($urandom);
      trc.ret_rd_wdata_i  = $urandom;
      trc.ret_trap_i      = 1'($urandom_range(0, 7) == 0);
      if (rst) begin
         m_q.delete();
         m_order = 0; m_drops = 0; m_ovf = 0; m_gap_pend = 0;
      end else begin
         cap = v && en;
         r = '{pc: pc, insn: trc.ret_insn_i, rd_we: trc.ret_rd_we_i,
               rd_addr: trc.ret_rd_addr_i, rd_wdata: trc.ret_rd_wdata_i,
               trap: trc.ret_trap_i, order: m_order, gap: m_gap_pend};
         if (cap) m_order = (m_order + 1) % (1 << ORDER_W);
         if (fl) begin
            m_q.delete();
            if (cap) m_gap_pend = 1;
         end else begin
            if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
            if (cap) begin
               if (m_q.size() < DEPTH) begin
                  m_q.push_back(r);
                  m_gap_pend = 0;
               end else begin
                  if (m_drops < DROP_MAX) m_drops++;
                  m_ovf = 1;
                  m_gap_pend = 1;
               end
            end
         end
      end
      @(posedge clk_i);
      #1;
      compare_model();
   endtask

   initial begin
      rst_i = 1; en_i = 0; flush_i = 0;
      trc.trace_ready_i = 0; trc.ret_valid_i = 0; trc.ret_pc_i = 0; trc.ret_insn_i = 0;
      trc.ret_rd_we_i = 0; trc.ret_rd_addr_i = 0; trc.ret_rd_wdata_i = 0; trc.ret_trap_i = 0;

      // Reset state and single-record latency
      step(1, 0, 0, 0, 0, 0);
      check_eq("rst_valid", 64'(trc.trace_valid_o), 0);
      check_eq("rst_pc", 64'(trc.trace_pc_o), 0);
      check_eq("rst_order", 64'(trc.trace_order_o), 0);
      check_eq("rst_gap", 64'(trc.trace_gap_o), 0);
      step(0, 1, 1, 0, 1, 32'h80);
      check_eq("t1_valid", 64'(trc.trace_valid_o), 1);
      check_eq("t1_pc", 64'(trc.trace_pc_o), 64'h80);
      check_eq("t1_order", 64'(trc.trace_order_o), 0);
      check_eq("t1_gap", 64'(trc.trace_gap_o), 0);
      step(0, 0, 1, 0, 1, 0);
      check_eq("t1_level", 64'(level_o), 0);

      // Overflow with backpressure, then drain and observe the gap
      step(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) step(0, 1, 1, 0, 0, 32'h200 + 32'(i * 4));
      check_eq("t2_level", 64'(level_o), 4);
      check_eq("t2_drop", 64'(drop_cnt_o), 2);
      check_eq("t2_ovf", 64'(overflow_o), 1);
      for (int i = 0; i < 4; i++) begin
         check_eq("t2_drain_order", 64'(trc.trace_order_o), 64'(i));
         step(0, 0, 1, 0, 1, 0);
      end
      step(0, 1, 1, 0, 0, 32'h300);
      check_eq("t2_next_order", 64'(trc.trace_order_o), 6);
      check_eq("t2_next_gap", 64'(trc.trace_gap_o), 1);

      // Full + pop + cap: no drop; then hold the head under backpressure
      step(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0, 32'h100 + 32'(i * 4));
      step(0, 1, 1, 0, 1, 32'h110);
      check_eq("t3_level", 64'(level_o), 4);
      check_eq("t3_drop", 64'(drop_cnt_o), 0);
      for (int i = 0; i < 5; i++) begin
         step(0, 1, 0, 0, 0, $urandom);
         check_eq("t4_pc", 64'(trc.trace_pc_o), 64'h104);
         check_eq("t4_order", 64'(trc.trace_order_o), 1);
      end

      // Flush with a capture in the same cycle
      step(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 32'h400 + 32'(i * 4));
      step(0, 1, 1, 1, 0, 32'h40c);
      check_eq("t5_level", 64'(level_o), 0);
      check_eq("t5_valid", 64'(trc.trace_valid_o), 0);
      step(0, 1, 1, 0, 0, 32'h410);
      check_eq("t5_order", 64'(trc.trace_order_o), 4);
      check_eq("t5_gap", 64'(trc.trace_gap_o), 1);
      check_eq("t5_drop", 64'(drop_cnt_o), 0);

      // Order wrap and drop-counter saturation
      step(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 17; i++) begin
         step(0, 1, 1, 0, 1, $urandom);
         check_eq("t6_order", 64'(trc.trace_order_o), 64'(i % 16));
      end
      step(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 9; i++) step(0, 1, 1, 0, 0, $urandom);
      check_eq("t6_drop_sat", 64'(drop_cnt_o), 3);

      // Random traffic including flush and mid-run reset
      step(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 1500; i++) begin
         step($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0,
              $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1, $urandom);
      end

      $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
      $finish;
   end
endmodule
